// File: rtl/vec_writeback.sv
// vec_writeback: write-back stage with a one-cycle scalar RF port and a lane-serialised vector RF port
// Optional `VEC_WB_FORWARD_EN adds EX-stage bypass outputs carrying the in-flight result
module vec_writeback #(
  parameter int SCAL_W = 21,
  parameter int VEC_W = 192,
  parameter int LANE_W = 24,
  parameter int DEST_W = 4,
  parameter int CNT_W = 16,
  localparam int LANES = VEC_W / LANE_W,
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_ctrl,
  input  logic              use_adder,
  input  logic [DEST_W-1:0] dest,
  input  logic [SCAL_W-1:0] res_alu_e,
  input  logic [VEC_W-1:0]  res_alu_ve,
  input  logic [VEC_W-1:0]  adder_vv,
  input  logic [VEC_W-1:0]  mem_data,
  output logic              sreg_we,
  output logic [DEST_W-1:0] sreg_addr,
  output logic [SCAL_W-1:0] sreg_wdata,
  output logic              vreg_we,
  output logic [DEST_W-1:0] vreg_addr,
  output logic [LW-1:0]     vreg_lane,
  output logic [LANE_W-1:0] vreg_wdata,
  output logic              busy,
  output logic [DEST_W-1:0] busy_dest,
  output logic              wb_done,
  output logic [CNT_W-1:0]  scal_cnt,
`ifdef VEC_WB_FORWARD_EN
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic              fwd_is_vec,
  output logic [SCAL_W-1:0] fwd_data_e,
  output logic [VEC_W-1:0]  fwd_data_v,
`endif
  output logic [CNT_W-1:0]  vec_cnt
);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  typedef enum logic {IDLE, VWRITE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lane;
  logic [DEST_W-1:0] vdest;
  logic [VEC_W-1:0] vdata;
  logic last, accept, acc_s, acc_v;
  assign last = state == VWRITE && lane == LAST;
  assign in_ready = state == IDLE || last;
  assign accept = in_valid && in_ready;
  assign acc_s = accept && wb_ctrl == 2'b01;
  assign acc_v = accept && wb_ctrl[1];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    busy = state == VWRITE;
    if (in_ready) state_nx = acc_v ? VWRITE : IDLE;
    vreg_we = busy;
    vreg_lane = lane;
    vreg_addr = busy ? vdest : '0;
    busy_dest = busy ? vdest : '0;
    vreg_wdata = busy ? vdata[lane*LANE_W +: LANE_W] : '0;
    wb_done = sreg_we || last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      vdest <= '0;
      vdata <= '0;
      sreg_we <= 1'b0;
      sreg_addr <= '0;
      sreg_wdata <= '0;
      scal_cnt <= '0;
      vec_cnt <= '0;
    end else begin
      sreg_we <= acc_s;
      if (acc_s) begin
        sreg_addr <= dest;
        sreg_wdata <= res_alu_e;
      end
      if (acc_s && !(&scal_cnt)) scal_cnt <= scal_cnt + 1'b1;
      if (last && !(&vec_cnt)) vec_cnt <= vec_cnt + 1'b1;
      lane <= (state == VWRITE && !last) ? lane + 1'b1 : '0;
      if (acc_v) begin
        vdest <= dest;
        vdata <= wb_ctrl[0] ? mem_data : use_adder ? adder_vv : res_alu_ve;
      end
    end
  end
`ifdef VEC_WB_FORWARD_EN
  // scalar and vector writes never overlap, so one bypass port covers both
  assign fwd_valid = sreg_we || busy;
  assign fwd_is_vec = busy;
  assign fwd_dest = sreg_we ? sreg_addr : busy ? vdest : '0;
  assign fwd_data_e = sreg_we ? sreg_wdata : '0;
  assign fwd_data_v = busy ? vdata : '0;
`endif
endmodule
